// File: rtl/tcm_ifetch.sv
// rtl/tcm_ifetch.sv - TCM instruction fetch: doubleword requests, 2-deep tag queue, credit-gated prefetch FIFO
// Branches flush the FIFO and drop responses still in flight for the old stream.
module tcm_ifetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  output logic        mem_i_rd_o,
  output logic [31:0] mem_i_pc_o,
  output logic        mem_i_flush_o,
  output logic        mem_i_invalidate_o,
  input  logic        mem_i_accept_i,
  input  logic        mem_i_valid_i,
  input  logic        mem_i_error_i,
  input  logic [63:0] mem_i_inst_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  input  logic        fetch_accept_i
);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  state_t state_q, state_d;

  logic [31:0]   pc_q;
  logic [1:0]    out_q, discard_q;
  logic [31:0]   tag_q [2];
  logic          tag_wr_q, tag_rd_q;

  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic          fifo_fault [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nx;
  logic [AW:0]   count_q, free, push_cnt;

  logic          credit, fire, resp, keep, push_one, push_two, pop;
  logic [31:0]   tag, e0_pc, e0_instr;
  logic          e0_fault;
  logic          unused_bits;

  assign unused_bits = ^branch_pc_i[1:0];

  // Reserve two slots per request (outstanding plus the one being issued) so responses always fit.
  assign free   = DEPTH - count_q;
  assign credit = int'(free) >= 2 * (int'(out_q) + 1);

  assign fire     = mem_i_rd_o & mem_i_accept_i;
  assign resp     = mem_i_valid_i & (out_q != 2'd0);
  assign tag      = tag_q[tag_rd_q];
  assign keep     = resp & (discard_q == 2'd0) & ~branch_request_i & (state_q == RUN);
  assign push_two = keep & ~mem_i_error_i & ~tag[2];
  assign push_one = keep & (mem_i_error_i | tag[2]);
  assign pop      = fetch_valid_o & fetch_accept_i & ~branch_request_i;
  assign push_cnt = push_two ? (AW+1)'(2) : (AW+1)'(push_one);
  assign wr_ptr_nx = wr_ptr_q + (AW)'(1);

  always_comb begin
    state_d    = state_q;
    mem_i_rd_o = 1'b0;
    if (branch_request_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          mem_i_rd_o = rst_ni & (out_q < 2'd2) & credit;
          if (push_one & mem_i_error_i) state_d = HALT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    e0_fault = mem_i_error_i;
    e0_pc    = tag;
    e0_instr = mem_i_inst_i[63:32];
    if (mem_i_error_i) begin
      e0_instr = 32'd0;
    end else if (!tag[2]) begin
      e0_pc    = {tag[31:3], 3'b000};
      e0_instr = mem_i_inst_i[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= BOOT_ADDR;
      out_q     <= 2'd0;
      discard_q <= 2'd0;
      tag_wr_q  <= 1'b0;
      tag_rd_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      out_q <= out_q + {1'b0, fire} - {1'b0, resp};
      if (fire) tag_wr_q <= ~tag_wr_q;
      if (resp) tag_rd_q <= ~tag_rd_q;
      if (branch_request_i) begin
        pc_q      <= {branch_pc_i[31:2], 2'b00};
        discard_q <= out_q - {1'b0, resp};
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
      end else begin
        if (fire) pc_q <= {pc_q[31:3] + 29'd1, 3'b000};
        if (resp && discard_q != 2'd0) discard_q <= discard_q - 2'd1;
        wr_ptr_q <= wr_ptr_q + push_cnt[AW-1:0];
        rd_ptr_q <= rd_ptr_q + (AW)'(pop);
        count_q  <= count_q + push_cnt - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fire) tag_q[tag_wr_q] <= pc_q;
    if (push_one | push_two) begin
      fifo_instr[wr_ptr_q] <= e0_instr;
      fifo_pc[wr_ptr_q]    <= e0_pc;
      fifo_fault[wr_ptr_q] <= e0_fault;
    end
    if (push_two) begin
      fifo_instr[wr_ptr_nx] <= mem_i_inst_i[63:32];
      fifo_pc[wr_ptr_nx]    <= {tag[31:3], 3'b100};
      fifo_fault[wr_ptr_nx] <= 1'b0;
    end
  end

  assign mem_i_pc_o         = {pc_q[31:3], 3'b000};
  assign mem_i_flush_o      = 1'b0;
  assign mem_i_invalidate_o = 1'b0;

  // Gate the head with valid so an empty FIFO presents zeros rather than stale storage.
  assign fetch_valid_o = (count_q != '0);
  assign fetch_instr_o = fetch_valid_o ? fifo_instr[rd_ptr_q] : 32'd0;
  assign fetch_pc_o    = fetch_valid_o ? fifo_pc[rd_ptr_q]    : 32'd0;
  assign fetch_fault_o = fetch_valid_o & fifo_fault[rd_ptr_q];

endmodule

// File: tb/tb_tcm_ifetch.sv
// tb/tb_tcm_ifetch.sv - directed bench for tcm_ifetch: vector table plus branch/error/wrap/reset sequences
module tb_tcm_ifetch;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic        mem_i_rd_o;
  logic [31:0] mem_i_pc_o;
  logic        mem_i_flush_o;
  logic        mem_i_invalidate_o;
  logic        mem_i_accept_i;
  logic        mem_i_valid_i;
  logic        mem_i_error_i;
  logic [63:0] mem_i_inst_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_fault_o;
  logic        fetch_accept_i;

  tcm_ifetch #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
    .mem_i_rd_o(mem_i_rd_o), .mem_i_pc_o(mem_i_pc_o),
    .mem_i_flush_o(mem_i_flush_o), .mem_i_invalidate_o(mem_i_invalidate_o),
    .mem_i_accept_i(mem_i_accept_i), .mem_i_valid_i(mem_i_valid_i),
    .mem_i_error_i(mem_i_error_i), .mem_i_inst_i(mem_i_inst_i),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
    .fetch_pc_o(fetch_pc_o), .fetch_fault_o(fetch_fault_o),
    .fetch_accept_i(fetch_accept_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [63:0] inst;
    logic        rd;
    logic [31:0] mpc;
    logic        fv;
    logic [31:0] fpc;
    logic [31:0] fin;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        got[$];
  logic        auto_mem;
  logic [31:0] err_pc;
  logic        s_rd;
  logic [31:0] s_mpc;
  int          rd_cnt;
  vec_t        tbl[10];

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ent(input string name, input int idx, input logic [31:0] pc,
                         input logic [31:0] instr, input logic fault);
    if (got.size() <= idx) begin
      chk({name, " count"}, 64'(got.size()), 64'(idx + 1));
    end else begin
      chk({name, " pc"}, {32'd0, got[idx].pc}, {32'd0, pc});
      chk({name, " instr"}, {32'd0, got[idx].instr}, {32'd0, instr});
      chk({name, " fault"}, {63'd0, got[idx].fault}, {63'd0, fault});
    end
  endtask

  // One clock: sample at negedge, then update stimulus 1 time unit after the rising edge.
  task automatic cycle();
    logic        req;
    logic [31:0] rpc;
    @(negedge clk_i);
    s_rd  = mem_i_rd_o;
    s_mpc = mem_i_pc_o;
    if (mem_i_rd_o) rd_cnt++;
    if (fetch_valid_o && fetch_accept_i && !branch_request_i)
      got.push_back('{fetch_pc_o, fetch_instr_o, fetch_fault_o});
    req = mem_i_rd_o & mem_i_accept_i;
    rpc = mem_i_pc_o;
    @(posedge clk_i);
    #1;
    branch_request_i = 1'b0;
    if (auto_mem) begin
      mem_i_valid_i = req;
      mem_i_inst_i  = {w(rpc + 32'd4), w(rpc)};
      mem_i_error_i = req && (rpc == err_pc);
    end
  endtask

  task automatic do_reset();
    rst_ni           = 1'b0;
    auto_mem         = 1'b0;
    mem_i_valid_i    = 1'b0;
    mem_i_error_i    = 1'b0;
    mem_i_inst_i     = 64'd0;
    branch_request_i = 1'b0;
    err_pc           = 32'h1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    got.delete();
    rd_cnt = 0;
  endtask

  initial begin
    rst_ni           = 1'b0;
    branch_request_i = 1'b0;
    branch_pc_i      = 32'd0;
    mem_i_accept_i   = 1'b1;
    mem_i_valid_i    = 1'b0;
    mem_i_error_i    = 1'b0;
    mem_i_inst_i     = 64'd0;
    fetch_accept_i   = 1'b1;
    auto_mem         = 1'b0;
    err_pc           = 32'h1;
    rd_cnt           = 0;

    tbl[0] = '{1'b0, 64'd0,               1'b1, 32'd0,  1'b0, 32'd0,  32'd0};
    tbl[1] = '{1'b1, {w(32'd4),  w(32'd0)},  1'b1, 32'd8,  1'b0, 32'd0,  32'd0};
    tbl[2] = '{1'b1, {w(32'd12), w(32'd8)},  1'b0, 32'd16, 1'b1, 32'd0,  w(32'd0)};
    tbl[3] = '{1'b0, 64'd0,               1'b0, 32'd16, 1'b1, 32'd4,  w(32'd4)};
    tbl[4] = '{1'b0, 64'd0,               1'b1, 32'd16, 1'b1, 32'd8,  w(32'd8)};
    tbl[5] = '{1'b1, {w(32'd20), w(32'd16)}, 1'b0, 32'd24, 1'b1, 32'd12, w(32'd12)};
    tbl[6] = '{1'b0, 64'd0,               1'b1, 32'd24, 1'b1, 32'd16, w(32'd16)};
    tbl[7] = '{1'b1, {w(32'd28), w(32'd24)}, 1'b0, 32'd32, 1'b1, 32'd20, w(32'd20)};
    tbl[8] = '{1'b0, 64'd0,               1'b1, 32'd32, 1'b1, 32'd24, w(32'd24)};
    tbl[9] = '{1'b1, {w(32'd36), w(32'd32)}, 1'b0, 32'd40, 1'b1, 32'd28, w(32'd28)};

    // Values held during reset
    #3;
    chk("reset rd", {63'd0, mem_i_rd_o}, 64'd0);
    chk("reset mpc", {32'd0, mem_i_pc_o}, 64'd0);
    chk("reset fv", {63'd0, fetch_valid_o}, 64'd0);
    chk("reset fpc", {32'd0, fetch_pc_o}, 64'd0);
    chk("reset fin", {32'd0, fetch_instr_o}, 64'd0);
    chk("reset fault", {63'd0, fetch_fault_o}, 64'd0);
    chk("flush/inval", {62'd0, mem_i_flush_o, mem_i_invalidate_o}, 64'd0);

    // Streaming vectors, memory driven straight from the table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mem_i_valid_i = tbl[i].valid;
      mem_i_inst_i  = tbl[i].inst;
      @(negedge clk_i);
      chk($sformatf("vec%0d rd", i),  {63'd0, mem_i_rd_o},    {63'd0, tbl[i].rd});
      chk($sformatf("vec%0d mpc", i), {32'd0, mem_i_pc_o},    {32'd0, tbl[i].mpc});
      chk($sformatf("vec%0d fv", i),  {63'd0, fetch_valid_o}, {63'd0, tbl[i].fv});
      chk($sformatf("vec%0d fpc", i), {32'd0, fetch_pc_o},    {32'd0, tbl[i].fpc});
      chk($sformatf("vec%0d fin", i), {32'd0, fetch_instr_o}, {32'd0, tbl[i].fin});
      chk($sformatf("vec%0d flt", i), {63'd0, fetch_fault_o}, 64'd0);
      @(posedge clk_i);
      #1;
    end

    // Back-pressure: FIFO fills with 4 words, then requests stop
    do_reset();
    auto_mem = 1'b1;
    fetch_accept_i = 1'b0;
    repeat (20) cycle();
    chk("bp requests", 64'(rd_cnt), 64'd2);
    chk("bp held valid", {63'd0, fetch_valid_o}, 64'd1);
    chk("bp head pc", {32'd0, fetch_pc_o}, 64'd0);
    fetch_accept_i = 1'b1;
    repeat (30) cycle();
    chk("bp drained enough", 64'(got.size() >= 12), 64'd1);
    for (int i = 0; i < 12; i++) chk_ent($sformatf("bp e%0d", i), i, 32'(4 * i), w(32'(4 * i)), 1'b0);

    // Branch with two requests outstanding
    do_reset();
    cycle();
    chk("br c0 rd", {63'd0, s_rd}, 64'd1);
    cycle();
    chk("br c1 rd", {63'd0, s_rd}, 64'd1);
    chk("br c1 mpc", {32'd0, s_mpc}, 64'h8);
    branch_request_i = 1'b1;
    branch_pc_i      = 32'h0000_0104;
    cycle();
    chk("br c2 rd", {63'd0, s_rd}, 64'd0);
    mem_i_valid_i = 1'b1;
    mem_i_inst_i  = {w(32'h4), w(32'h0)};
    cycle();
    chk("br c3 rd", {63'd0, s_rd}, 64'd0);
    mem_i_inst_i  = {w(32'hC), w(32'h8)};
    cycle();
    chk("br c4 rd", {63'd0, s_rd}, 64'd1);
    chk("br c4 mpc", {32'd0, s_mpc}, 64'h100);
    mem_i_inst_i  = {w(32'h104), w(32'h100)};
    auto_mem = 1'b1;
    repeat (10) cycle();
    chk_ent("br e0", 0, 32'h104, w(32'h104), 1'b0);
    chk_ent("br e1", 1, 32'h108, w(32'h108), 1'b0);
    chk_ent("br e2", 2, 32'h10C, w(32'h10C), 1'b0);

    // Error response at 0x20 halts fetch until a branch
    do_reset();
    auto_mem = 1'b1;
    err_pc = 32'h20;
    repeat (25) cycle();
    chk("err entries", 64'(got.size()), 64'd9);
    for (int i = 0; i < 8; i++) chk_ent($sformatf("err e%0d", i), i, 32'(4 * i), w(32'(4 * i)), 1'b0);
    chk_ent("err fault", 8, 32'h20, 32'd0, 1'b1);
    chk("err requests", 64'(rd_cnt), 64'd5);
    err_pc = 32'h1;
    got.delete();
    rd_cnt = 0;
    branch_request_i = 1'b1;
    branch_pc_i      = 32'h0000_0200;
    cycle();
    repeat (10) cycle();
    chk("err resumed", 64'(rd_cnt > 0), 64'd1);
    chk_ent("err resume e0", 0, 32'h200, w(32'h200), 1'b0);
    chk_ent("err resume e1", 1, 32'h204, w(32'h204), 1'b0);

    // Address wrap, branch taken with nothing in flight
    do_reset();
    auto_mem = 1'b1;
    branch_request_i = 1'b1;
    branch_pc_i      = 32'hFFFF_FFF8;
    cycle();
    chk("wrap br rd", {63'd0, s_rd}, 64'd0);
    cycle();
    chk("wrap next rd", {63'd0, s_rd}, 64'd1);
    chk("wrap next mpc", {32'd0, s_mpc}, 64'hFFFF_FFF8);
    repeat (8) cycle();
    chk_ent("wrap e0", 0, 32'hFFFF_FFF8, w(32'hFFFF_FFF8), 1'b0);
    chk_ent("wrap e1", 1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC), 1'b0);
    chk_ent("wrap e2", 2, 32'h0, w(32'h0), 1'b0);

    // Asynchronous reset pulse with a response pending
    do_reset();
    auto_mem = 1'b1;
    fetch_accept_i = 1'b0;
    cycle();
    cycle();
    chk("rst pre fv", {63'd0, fetch_valid_o}, 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst async fv", {63'd0, fetch_valid_o}, 64'd0);
    chk("rst async fpc", {32'd0, fetch_pc_o}, 64'd0);
    chk("rst async fin", {32'd0, fetch_instr_o}, 64'd0);
    chk("rst async rd", {63'd0, mem_i_rd_o}, 64'd0);
    auto_mem = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    fetch_accept_i = 1'b1;
    got.delete();
    cycle();
    chk("rst first rd", {63'd0, s_rd}, 64'd1);
    chk("rst first mpc", {32'd0, s_mpc}, 64'd0);
    mem_i_valid_i = 1'b1;
    mem_i_inst_i  = {w(32'h4), w(32'h0)};
    auto_mem = 1'b1;
    repeat (10) cycle();
    chk_ent("rst e0", 0, 32'h0, w(32'h0), 1'b0);
    chk_ent("rst e1", 1, 32'h4, w(32'h4), 1'b0);
    chk_ent("rst e2", 2, 32'h8, w(32'h8), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
